// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift_seq_reg datapath: step-mode codes and
// the sequencing FSM state encoding.
package shift_reg_pkg;

    // Step-mode codes presented on the mode input (code 7 is reserved and
    // behaves as HOLD).
    localparam logic [2:0] MODE_HOLD      = 3'd0;
    localparam logic [2:0] MODE_LOAD      = 3'd1;
    localparam logic [2:0] MODE_SRL       = 3'd2;
    localparam logic [2:0] MODE_SRA       = 3'd3;
    localparam logic [2:0] MODE_SLL       = 3'd4;
    localparam logic [2:0] MODE_ROR       = 3'd5;
    localparam logic [2:0] MODE_ADD_SHIFT = 3'd6;

    // Sequencer states: IDLE accepts start/enable, RUN steps autonomously,
    // DONE emits the one-cycle completion pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational next-state function of the 2N-bit register for one step of
// the selected mode. Shared by the single-step path and the autonomous run.
module shift_step_unit
    import shift_reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2*N-1:0] i_q,
    input  logic [2:0]     i_mode,
    input  logic [N-1:0]   i_in,
    input  logic [N:0]     i_hi_in,
    output logic [2*N-1:0] o_q_next,
    output logic           o_sout,
    output logic           o_shifts
);

    // Compute next register value, the shifted-out bit and whether this mode shifts.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        o_q_next = i_q;
        o_sout   = 1'b0;
        o_shifts = 1'b0;
        case (i_mode)
            MODE_LOAD: begin
                o_q_next = {{N{1'b0}}, i_in};
            end
            MODE_SRL: begin
                o_q_next = {1'b0, i_q[2*N-1:1]};
                o_sout   = i_q[0];
                o_shifts = 1'b1;
            end
            MODE_SRA: begin
                o_q_next = {i_q[2*N-1], i_q[2*N-1:1]};
                o_sout   = i_q[0];
                o_shifts = 1'b1;
            end
            MODE_SLL: begin
                o_q_next = {i_q[2*N-2:0], 1'b0};
                o_sout   = i_q[2*N-1];
                o_shifts = 1'b1;
            end
            MODE_ROR: begin
                o_q_next = {i_q[0], i_q[2*N-1:1]};
                o_sout   = i_q[0];
                o_shifts = 1'b1;
            end
            MODE_ADD_SHIFT: begin
                // Adder result {carry, sum} replaces the high half while the
                // low half (multiplier bits) moves down by one.
                o_q_next = {i_hi_in, i_q[N-1:1]};
                o_sout   = i_q[0];
                o_shifts = 1'b1;
            end
            default: begin
                // HOLD and the reserved code leave the register unchanged.
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_reg.sv
// 2N-bit parallel-in/parallel-out shift register for the shift-add
// multiplier. Supports single steps under enable and autonomous runs of a
// programmed number of steps with a start/busy/done handshake.
module shift_seq_reg
    import shift_reg_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(2*N+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   IN,
    input  logic [N:0]     HI_IN,
    input  logic [2:0]     mode,
    input  logic           enable,
    input  logic           start,
    input  logic [CW-1:0]  count,
    output logic [2*N-1:0] Q,
    output logic           sout,
    output logic           busy,
    output logic           done
);

    localparam logic [CW-1:0] MAX_STEPS = CW'(2*N);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_run_mode;

    logic [CW-1:0]  w_count_clamped;
    logic [2:0]     w_step_mode;
    logic [2*N-1:0] w_q_next;
    logic           w_sout;
    logic           w_shifts;

    // More than 2N steps is never useful, so longer requests saturate.
    assign w_count_clamped = (count > MAX_STEPS) ? MAX_STEPS : count;

    // During a run the latched mode drives the step unit; mode input is ignored.
    assign w_step_mode = (r_state == ST_RUN) ? r_run_mode : mode;

    shift_step_unit #(
        .N (N)
    ) u_step (
        .i_q      (Q),
        .i_mode   (w_step_mode),
        .i_in     (IN),
        .i_hi_in  (HI_IN),
        .o_q_next (w_q_next),
        .o_sout   (w_sout),
        .o_shifts (w_shifts)
    );

    // Sequencer FSM with registered outputs, step counter and data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_run_mode <= MODE_HOLD;
            Q          <= '0;
            sout       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, matching real flip-flop behaviour.
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // start wins over enable; no step on the accepting edge.
                        if (w_count_clamped != '0) begin
                            r_run_mode <= mode;
                            r_cnt      <= w_count_clamped;
                            busy       <= 1'b1;
                            r_state    <= ST_RUN;
                        end else begin
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else if (enable) begin
                        Q <= w_q_next;
                        if (w_shifts) begin
                            sout <= w_sout;
                        end
                    end
                end
                ST_RUN: begin
                    Q <= w_q_next;
                    if (w_shifts) begin
                        sout <= w_sout;
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_reg.sv
// Scoreboard bench for shift_seq_reg (N=8): runs push their expected result
// into a queue; a monitor pops and compares at every done pulse.
module tb_shift_seq_reg;
    import shift_reg_pkg::*;

    localparam int N  = 8;
    localparam int CW = $clog2(2*N+1);

    typedef struct {
        string       name;
        logic [15:0] q;
        logic        sout;
        int          busy_cycles;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  in_val;
    logic [N:0]    hi_in;
    logic [2:0]    mode;
    logic          enable;
    logic          start;
    logic [CW-1:0] count;
    logic [15:0]   q;
    logic          sout;
    logic          busy;
    logic          done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    shift_seq_reg #(
        .N (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .IN     (in_val),
        .HI_IN  (hi_in),
        .mode   (mode),
        .enable (enable),
        .start  (start),
        .count  (count),
        .Q      (q),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier adder model: multiplicand 0x0B added when the low bit is set.
    always_comb hi_in = {1'b0, q[15:8]} + (q[0] ? 9'd11 : 9'd0);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: counts busy cycles and scores every done pulse against the queue.
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "_q"}, 32'(q), 32'(e.q));
                    check({e.name, "_sout"}, 32'(sout), 32'(e.sout));
                    check({e.name, "_busy_len"}, 32'(busy_cnt), 32'(e.busy_cycles));
                    check({e.name, "_busy_low"}, 32'(busy), 32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic step(input logic [2:0] m, input logic [7:0] v);
        @(negedge clk);
        mode   = m;
        in_val = v;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] m, input logic [CW-1:0] c,
                       input logic with_enable, input logic [15:0] exp_q,
                       input logic exp_sout, input int exp_busy);
        exp_t e;
        bit   seen;
        e.name = name; e.q = exp_q; e.sout = exp_sout; e.busy_cycles = exp_busy;
        sb_q.push_back(e);
        @(negedge clk);
        mode   = m;
        count  = c;
        start  = 1'b1;
        enable = with_enable;
        @(negedge clk);
        start  = 1'b0;
        enable = 1'b0;
        seen   = done;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_val = '0; mode = MODE_HOLD; enable = 1'b0; start = 1'b0; count = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-cycle clears everything without a clock edge.
        step(MODE_LOAD, 8'h81);
        check("load_81", 32'(q), 32'h0081);
        step(MODE_SRL, 8'h00);
        check("srl_step_q", 32'(q), 32'h0040);
        check("srl_step_sout", 32'(sout), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", 32'(q), 32'h0000);
        check("async_rst_sout", 32'(sout), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load and shift left.
        step(MODE_LOAD, 8'hA5);
        check("load_a5", 32'(q), 32'h00A5);
        run("sll8", MODE_SLL, 5'd8, 1'b0, 16'hA500, 1'b0, 8);

        // Over-range count clamps to 16: full rotation, last bit out is old Q[15].
        run("ror31", MODE_ROR, 5'd31, 1'b0, 16'hA500, 1'b1, 16);

        // Zero-length run: done next cycle, Q and sout unchanged, never busy.
        run("cnt0", MODE_SRL, 5'd0, 1'b0, 16'hA500, 1'b1, 0);

        // Arithmetic right shift from 0x8000.
        step(MODE_LOAD, 8'h80);
        run("mk8000_a", MODE_SLL, 5'd8, 1'b0, 16'h8000, 1'b0, 8);
        run("sra3", MODE_SRA, 5'd3, 1'b0, 16'hF000, 1'b0, 3);

        // start together with enable: enable must not add an extra step.
        run("start_en", MODE_SRL, 5'd2, 1'b1, 16'h3C00, 1'b0, 2);

        // Logical right shift from 0x8000.
        step(MODE_LOAD, 8'h80);
        run("mk8000_b", MODE_SLL, 5'd8, 1'b0, 16'h8000, 1'b0, 8);
        run("srl3", MODE_SRL, 5'd3, 1'b0, 16'h1000, 1'b0, 3);

        // Shift-add multiply 13 x 11 = 143.
        step(MODE_LOAD, 8'h0D);
        run("mult", MODE_ADD_SHIFT, 5'd8, 1'b0, 16'h008F, 1'b0, 8);

        // Single steps after the product.
        step(MODE_SRL, 8'h00);
        check("step_srl_q", 32'(q), 32'h0047);
        check("step_srl_sout", 32'(sout), 32'd1);
        step(MODE_SLL, 8'h00);
        check("step_sll_q", 32'(q), 32'h008E);
        check("step_sll_sout", 32'(sout), 32'd0);
        step(3'd7, 8'hFF);
        check("step_rsvd_q", 32'(q), 32'h008E);

        // Reset in the middle of a run: no done may follow.
        step(MODE_LOAD, 8'h33);
        @(negedge clk);
        mode = MODE_ROR; count = 5'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("run_rst_q", 32'(q), 32'h0000);
        check("run_rst_busy", 32'(busy), 32'd0);
        check("run_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done), 32'd0);
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
